// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: control and instruction memory
// inputs, plus the IF/ID register and decoded-field outputs.
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pcplus4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_index, imem_data,
    output imem_addr, if_id_instr, if_id_pcplus4, if_id_valid,
           opcode, rs, rt, rd, shamt, funct, imm16, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_index, imem_data,
    input  imem_addr, if_id_instr, if_id_pcplus4, if_id_valid,
           opcode, rs, rt, rd, shamt, funct, imm16, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a count of valid fetches.
// Redirects flush IF/ID with a bubble and take priority over stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master fif
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (fif.branch_taken || fif.jump) begin
      // Branch beats jump; the jump region comes from the instruction currently in IF/ID.
      if (fif.branch_taken) pc_d = {fif.branch_target[31:2], 2'b00};
      else                  pc_d = {pcplus4_q[31:28], fif.jump_index, 2'b00};
      instr_d   = 32'h0000_0000;
      pcplus4_d = 32'h0000_0000;
      valid_d   = 1'b0;
    end else if (!fif.stall) begin
      pc_d      = pc_plus4;
      instr_d   = fif.imem_data;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
      count_d   = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      pcplus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
      count_q   <= 32'h0000_0000;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign fif.imem_addr     = pc_q;
  assign fif.if_id_instr   = instr_q;
  assign fif.if_id_pcplus4 = pcplus4_q;
  assign fif.if_id_valid   = valid_q;
  assign fif.fetch_count   = count_q;
  // Bubbles hold an all-zero word, so every field reads zero without extra gating.
  assign fif.opcode = instr_q[31:26];
  assign fif.rs     = instr_q[25:21];
  assign fif.rt     = instr_q[20:16];
  assign fif.rd     = instr_q[15:11];
  assign fif.shamt  = instr_q[10:6];
  assign fif.funct  = instr_q[5:0];
  assign fif.imm16  = instr_q[15:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a per-edge behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_total = 0;
  int n_pass = 0;
  bit mid_check = 1'b0;

  always #5 clk = ~clk;

  fetch_stage_if fif ();
  fetch_stage_if fif2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .fif(fif));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset(reset), .fif(fif2));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0022_1820;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign fif.imem_data  = mem_word(fif.imem_addr);
  assign fif2.imem_data = mem_word(fif2.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_instr, m_pp4, m_count;
  logic        m_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    end else if (fif.branch_taken || fif.jump) begin
      if (fif.branch_taken) m_pc = fif.branch_target & ~32'h3;
      else m_pc = (m_pp4 & 32'hF000_0000) | ({6'b0, fif.jump_index} << 2);
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (!fif.stall) begin
      m_instr = mem_word(m_pc);
      m_pp4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("imem_addr", fif.imem_addr, m_pc);
      chk("if_id_instr", fif.if_id_instr, m_instr);
      chk("if_id_pcplus4", fif.if_id_pcplus4, m_pp4);
      chk("if_id_valid", {31'b0, fif.if_id_valid}, {31'b0, m_valid});
      chk("fetch_count", fif.fetch_count, m_count);
      chk("opcode", {26'b0, fif.opcode}, m_instr >> 26);
      chk("rs", {27'b0, fif.rs}, (m_instr >> 21) % 32);
      chk("rt", {27'b0, fif.rt}, (m_instr >> 16) % 32);
      chk("rd", {27'b0, fif.rd}, (m_instr >> 11) % 32);
      chk("shamt", {27'b0, fif.shamt}, (m_instr >> 6) % 32);
      chk("funct", {26'b0, fif.funct}, m_instr % 64);
      chk("imm16", {16'b0, fif.imm16}, m_instr % 65536);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = 32'h0;
    fif.jump = 1'b0; fif.jump_index = 26'h0;
  endtask

  // Leaves IF/ID holding the instruction fetched from 0x1000_0004 (pcplus4 = 0x1000_0008).
  task automatic setup_pp4();
    idle_inputs();
    fif.branch_taken = 1'b1; fif.branch_target = 32'h1000_0004;
    step();
    idle_inputs();
    step();
    chk("setup_pp4", fif.if_id_pcplus4, 32'h1000_0008);
  endtask

  initial begin
    idle_inputs();
    fif2.stall = 1'b0; fif2.branch_taken = 1'b0; fif2.branch_target = 32'h0;
    fif2.jump = 1'b0; fif2.jump_index = 26'h0;
    step();
    chk("rst_addr", fif.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, fif.if_id_valid}, 32'h0);
    chk("rst_count", fif.fetch_count, 32'h0);
    chk("rst2_addr", fif2.imem_addr, 32'hFFFF_FFFC);
    step();
    reset = 1'b0;

    // First fetch after release
    step();
    chk("f1_instr", fif.if_id_instr, 32'h0022_1820);
    chk("f1_rs", {27'b0, fif.rs}, 32'd1);
    chk("f1_rt", {27'b0, fif.rt}, 32'd2);
    chk("f1_rd", {27'b0, fif.rd}, 32'd3);
    chk("f1_funct", {26'b0, fif.funct}, 32'h20);
    chk("f1_pcplus4", fif.if_id_pcplus4, 32'd4);
    chk("f1_addr", fif.imem_addr, 32'd4);
    chk("f1_count", fif.fetch_count, 32'd1);
    chk("wrap_addr", fif2.imem_addr, 32'h0);
    chk("wrap_pcplus4", fif2.if_id_pcplus4, 32'h0);
    chk("wrap_valid", {31'b0, fif2.if_id_valid}, 32'd1);

    // Stall holds everything
    step(); step();
    chk("pre_stall_addr", fif.imem_addr, 32'd12);
    chk("pre_stall_count", fif.fetch_count, 32'd3);
    fif.stall = 1'b1;
    step(); step();
    chk("stall_addr", fif.imem_addr, 32'd12);
    chk("stall_count", fif.fetch_count, 32'd3);
    chk("stall_instr", fif.if_id_instr, mem_word(32'd8));
    fif.stall = 1'b0;
    step();
    chk("resume_pcplus4", fif.if_id_pcplus4, 32'd16);
    chk("resume_instr", fif.if_id_instr, mem_word(32'd12));

    // Branch with misaligned target
    fif.branch_taken = 1'b1; fif.branch_target = 32'h0000_0043;
    step();
    chk("br_addr", fif.imem_addr, 32'h40);
    chk("br_valid", {31'b0, fif.if_id_valid}, 32'd0);
    chk("br_instr", fif.if_id_instr, 32'h0);
    chk("br_funct", {26'b0, fif.funct}, 32'h0);
    chk("br_count", fif.fetch_count, 32'd4);
    idle_inputs();
    step();
    chk("br_fetch_pcplus4", fif.if_id_pcplus4, 32'h44);
    chk("br_fetch_instr", fif.if_id_instr, mem_word(32'h40));

    // Jump, branch-over-jump, and redirect-over-stall
    setup_pp4();
    fif.jump = 1'b1; fif.jump_index = 26'h000_0010;
    step();
    chk("jmp_addr", fif.imem_addr, 32'h1000_0040);
    setup_pp4();
    fif.jump = 1'b1; fif.jump_index = 26'h000_0010;
    fif.branch_taken = 1'b1; fif.branch_target = 32'h80;
    step();
    chk("br_over_jmp", fif.imem_addr, 32'h80);
    setup_pp4();
    fif.jump = 1'b1; fif.jump_index = 26'h000_0010;
    fif.branch_taken = 1'b1; fif.branch_target = 32'h80;
    fif.stall = 1'b1;
    step();
    chk("redir_over_stall", fif.imem_addr, 32'h80);
    chk("redir_stall_valid", {31'b0, fif.if_id_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      fif.stall         = ($urandom % 4) == 0;
      fif.branch_taken  = ($urandom % 8) == 0;
      fif.jump          = ($urandom % 8) == 0;
      fif.branch_target = $urandom;
      fif.jump_index    = 26'($urandom);
      step();
    end

    // Async reset between edges during a stall
    idle_inputs();
    step();
    fif.stall = 1'b1;
    step();
    #2;
    reset = 1'b1;
    #1;
    mid_check = 1'b1;
    chk("arst_addr", fif.imem_addr, 32'h0);
    chk("arst_instr", fif.if_id_instr, 32'h0);
    chk("arst_pcplus4", fif.if_id_pcplus4, 32'h0);
    chk("arst_valid", {31'b0, fif.if_id_valid}, 32'h0);
    chk("arst_count", fif.fetch_count, 32'h0);
    chk("arst_rd", {27'b0, fif.rd}, 32'h0);
    fif.branch_taken = 1'b1; fif.branch_target = 32'h100;
    step();
    chk("arst_hold_addr", fif.imem_addr, 32'h0);
    chk("arst_hold_count", fif.fetch_count, 32'h0);
    reset = 1'b0;
    idle_inputs();
    step();
    chk("post_rst_instr", fif.if_id_instr, 32'h0022_1820);
    chk("post_rst_addr", fif.imem_addr, 32'd4);
    chk("post_rst_valid", {31'b0, fif.if_id_valid}, 32'd1);
    chk("post_rst_count", fif.fetch_count, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
